// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus (transmitter and receiver nodes).
// Contents: field widths, FSM state enum, CRC-4 polynomial (x^4+x+1) and
// the serial CRC-4 step function crc4_next(crc, din).
package bus_pkg;

  localparam int ADDR_W    = 4;
  localparam int MOD_W     = 2;
  localparam int DATA_W    = 64;
  localparam int CRC_W     = 4;
  localparam int FRAME_LEN = 79;

  // Bits covered by the CRC: src, dst, mod, data.
  localparam int HDR_BITS  = 2 * ADDR_W + MOD_W + DATA_W;
  localparam int CNT_W     = 7;

  localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRC,
    ST_DST,
    ST_MOD,
    ST_DATA,
    ST_CRC
  } rx_state_e;

  // One serial CRC step, MSB-first, no reflection.
  function automatic logic [CRC_W-1:0] crc4_next(input logic [CRC_W-1:0] crc,
                                                 input logic din);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/bus_rx_node_if.sv
// Receiver node bus interface.
// Signals: bus_in (serial line), rx_valid, rx_data, rx_src, rx_mod,
// crc_err, busy, rx_count.
// Modports: master drives the line and observes the node outputs;
// slave is the receiver node itself.
interface bus_rx_node_if;
  import bus_pkg::*;

  logic                bus_in;
  logic                rx_valid;
  logic [DATA_W-1:0]   rx_data;
  logic [ADDR_W-1:0]   rx_src;
  logic [MOD_W-1:0]    rx_mod;
  logic                crc_err;
  logic                busy;
  logic [7:0]          rx_count;

  modport master (
    output bus_in,
    input  rx_valid, rx_data, rx_src, rx_mod, crc_err, busy, rx_count
  );

  modport slave (
    input  bus_in,
    output rx_valid, rx_data, rx_src, rx_mod, crc_err, busy, rx_count
  );

endinterface

// File: rtl/bus_crc4_ser.sv
// Serial CRC-4 register (x^4+x+1, init 0).
// Ports: clk, rst (sync, active-high), clr (reload zero, wins over en),
// en (absorb din this cycle), din (serial bit), crc (current remainder).
module bus_crc4_ser
  import bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc4_next(crc_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/bus_rx_node.sv
// Serial bus receiver node: deframes 79-bit packets
// (start, src[3:0], dst[3:0], mod[1:0], data[63:0], crc[3:0], MSB first),
// filters on destination / broadcast mode and optionally checks CRC-4.
// Ports: clock, reset (sync, active-high), bus (bus_rx_node_if.slave:
// bus_in, rx_valid, rx_data, rx_src, rx_mod, crc_err, busy, rx_count).
// Parameters: MY_ADDR (node address), BCAST_MOD (broadcast mode value).
// Build option: define BUS_RX_CRC_CHECK_EN to enable CRC checking and
// crc_err; otherwise the crc field is shifted past and ignored.
module bus_rx_node
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MY_ADDR   = 4'd1,
  parameter logic [MOD_W-1:0]  BCAST_MOD = 2'b01
) (
  input  logic          clock,
  input  logic          reset,
  bus_rx_node_if.slave  bus
);

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HDR_BITS-1:0]   sr_q, sr_d;

  logic                  rx_valid_q, rx_valid_d;
  logic                  crc_err_q, crc_err_d;
  logic                  busy_q, busy_d;
  logic [DATA_W-1:0]     rx_data_q, rx_data_d;
  logic [ADDR_W-1:0]     rx_src_q, rx_src_d;
  logic [MOD_W-1:0]      rx_mod_q, rx_mod_d;
  logic [7:0]            rx_count_q, rx_count_d;

  logic [ADDR_W-1:0]     f_src, f_dst;
  logic [MOD_W-1:0]      f_mod;
  logic [DATA_W-1:0]     f_data;
  logic                  eval, match, crc_ok;

  // Header and data stay put in the shift register while the crc field
  // arrives, so the fields are stable on the evaluation edge.
  assign f_src  = sr_q[HDR_BITS-1 -: ADDR_W];
  assign f_dst  = sr_q[HDR_BITS-ADDR_W-1 -: ADDR_W];
  assign f_mod  = sr_q[DATA_W +: MOD_W];
  assign f_data = sr_q[DATA_W-1:0];

  assign eval  = (state_q == ST_CRC) && (cnt_q == '0);
  assign match = (f_dst == MY_ADDR) || (f_mod == BCAST_MOD);

`ifdef BUS_RX_CRC_CHECK_EN
  logic [CRC_W-1:0] crc_rx_q, crc_rx_d, crc_calc;
  logic             crc_clr, crc_en;

  assign crc_clr = (state_q == ST_IDLE);
  assign crc_en  = (state_q == ST_SRC) || (state_q == ST_DST) ||
                   (state_q == ST_MOD) || (state_q == ST_DATA);

  bus_crc4_ser u_crc (
    .clk (clock),
    .rst (reset),
    .clr (crc_clr),
    .en  (crc_en),
    .din (bus.bus_in),
    .crc (crc_calc)
  );

  always_comb begin
    crc_rx_d = crc_rx_q;
    if (state_q == ST_CRC) begin
      crc_rx_d = {crc_rx_q[CRC_W-2:0], bus.bus_in};
    end
  end

  // The last received crc bit is still on the line at evaluation time.
  assign crc_ok = (crc_calc == crc_rx_d);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rx_valid_d = 1'b0;
    crc_err_d  = 1'b0;
    rx_data_d  = rx_data_q;
    rx_src_d   = rx_src_q;
    rx_mod_d   = rx_mod_q;
    rx_count_d = rx_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.bus_in) begin
          state_d = ST_SRC;
          cnt_d   = CNT_W'(ADDR_W - 1);
        end
      end
      ST_SRC: begin
        sr_d = {sr_q[HDR_BITS-2:0], bus.bus_in};
        if (cnt_q == '0) begin
          state_d = ST_DST;
          cnt_d   = CNT_W'(ADDR_W - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DST: begin
        sr_d = {sr_q[HDR_BITS-2:0], bus.bus_in};
        if (cnt_q == '0) begin
          state_d = ST_MOD;
          cnt_d   = CNT_W'(MOD_W - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MOD: begin
        sr_d = {sr_q[HDR_BITS-2:0], bus.bus_in};
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        sr_d = {sr_q[HDR_BITS-2:0], bus.bus_in};
        if (cnt_q == '0) begin
          state_d = ST_CRC;
          cnt_d   = CNT_W'(CRC_W - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CRC: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (eval && match) begin
      if (crc_ok) begin
        rx_valid_d = 1'b1;
        rx_data_d  = f_data;
        rx_src_d   = f_src;
        rx_mod_d   = f_mod;
        rx_count_d = rx_count_q + 8'd1;
      end else begin
        crc_err_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      rx_valid_q <= 1'b0;
      crc_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_src_q   <= '0;
      rx_mod_q   <= '0;
      rx_count_q <= '0;
`ifdef BUS_RX_CRC_CHECK_EN
      crc_rx_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      rx_valid_q <= rx_valid_d;
      crc_err_q  <= crc_err_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_src_q   <= rx_src_d;
      rx_mod_q   <= rx_mod_d;
      rx_count_q <= rx_count_d;
`ifdef BUS_RX_CRC_CHECK_EN
      crc_rx_q   <= crc_rx_d;
`endif
    end
  end

  assign bus.rx_valid = rx_valid_q;
  assign bus.crc_err  = crc_err_q;
  assign bus.busy     = busy_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_src   = rx_src_q;
  assign bus.rx_mod   = rx_mod_q;
  assign bus.rx_count = rx_count_q;

endmodule

// File: tb/tb_bus_rx_node.sv
// Self-checking bench for bus_rx_node: frames are built as whole 79-bit
// vectors with a CRC from polynomial long division, and the expected node
// outputs are tracked cycle by cycle from the acceptance rules.
module tb_bus_rx_node;

  localparam logic [3:0] MY_ADDR   = 4'd1;
  localparam logic [1:0] BCAST_MOD = 2'b01;

  logic clk;
  logic rst;

  bus_rx_node_if intf ();

  bus_rx_node #(
    .MY_ADDR   (MY_ADDR),
    .BCAST_MOD (BCAST_MOD)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_valid = 0;

  // Expected outputs as seen at the next sampling point.
  logic        exp_valid, exp_err, exp_busy;
  logic [63:0] exp_data;
  logic [3:0]  exp_src;
  logic [1:0]  exp_mod;
  logic [7:0]  exp_count;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // CRC as remainder of msg * x^4 divided by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [73:0] msg);
    logic [77:0] rem;
    rem = {msg, 4'b0000};
    for (int i = 77; i >= 4; i--) begin
      if (rem[i]) rem[i -: 5] = rem[i -: 5] ^ 5'b10011;
    end
    return rem[3:0];
  endfunction

  function automatic logic [78:0] make_frame(input logic [3:0] src, input logic [3:0] dst,
                                             input logic [1:0] mod, input logic [63:0] data,
                                             input logic flip);
    logic [73:0] msg;
    msg = {src, dst, mod, data};
    return {1'b1, msg, ref_crc(msg) ^ {3'b000, flip}};
  endfunction

  // One bus cycle: check what the previous edge produced, then drive.
  task automatic step(input logic b, input logic r, input logic nb);
    @(negedge clk);
    check_eq("rx_valid", intf.rx_valid, exp_valid);
    check_eq("crc_err",  intf.crc_err,  exp_err);
    check_eq("busy",     intf.busy,     exp_busy);
    check_eq("rx_data",  intf.rx_data,  exp_data);
    check_eq("rx_src",   intf.rx_src,   exp_src);
    check_eq("rx_mod",   intf.rx_mod,   exp_mod);
    check_eq("rx_count", intf.rx_count, exp_count);
    if (intf.rx_valid === 1'b1) n_valid++;
    exp_valid   = 1'b0;
    exp_err     = 1'b0;
    rst         = r;
    intf.bus_in = b;
    exp_busy    = nb;
    if (r) begin
      exp_data  = '0;
      exp_src   = '0;
      exp_mod   = '0;
      exp_count = '0;
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [3:0] src, input logic [3:0] dst,
                            input logic [1:0] mod, input logic [63:0] data,
                            input logic flip);
    logic [78:0] fr;
    logic        hit, good;
    fr = make_frame(src, dst, mod, data, flip);
    for (int j = 0; j < 79; j++) step(fr[78-j], 1'b0, (j <= 77));
    hit = (dst == MY_ADDR) || (mod == BCAST_MOD);
`ifdef BUS_RX_CRC_CHECK_EN
    good = !flip;
`else
    good = 1'b1;
`endif
    if (hit && good) begin
      exp_valid = 1'b1;
      exp_data  = data;
      exp_src   = src;
      exp_mod   = mod;
      exp_count = exp_count + 8'd1;
    end else if (hit) begin
      exp_err = 1'b1;
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic [3:0]  rs, rdst;
    logic [1:0]  rm;
    logic        rf;

    rst         = 1'b1;
    intf.bus_in = 1'b0;
    exp_valid   = 1'b0;
    exp_err     = 1'b0;
    exp_busy    = 1'b0;
    exp_data    = '0;
    exp_src     = '0;
    exp_mod     = '0;
    exp_count   = '0;

    do_reset(3);
    idle(4);

    // Unicast, filtered, broadcast, corrupted CRC.
    send_frame(4'd0, 4'd1, 2'b01, 64'h1, 1'b0);
    idle(3);
    send_frame(4'd3, 4'd2, 2'b00, 64'hDEAD_BEEF, 1'b0);
    idle(3);
    send_frame(4'd5, 4'd7, 2'b01, 64'hFFFF_0000_FFFF_0000, 1'b0);
    idle(3);
    send_frame(4'd9, 4'd1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b1);
    idle(3);

    // Randomised frames with random gaps (including zero gap).
    for (int k = 0; k < 40; k++) begin
      rs   = 4'($urandom);
      rdst = ($urandom_range(0, 1) == 0) ? MY_ADDR : 4'($urandom);
      rm   = 2'($urandom);
      rd   = {32'($urandom), 32'($urandom)};
      rf   = ($urandom_range(0, 3) == 0);
      send_frame(rs, rdst, rm, rd, rf);
      idle($urandom_range(0, 3));
    end

    // 256 zero-gap frames: count wraps back to zero.
    do_reset(2);
    n_valid = 0;
    for (int k = 0; k < 256; k++) begin
      rd = {32'($urandom), 32'($urandom)};
      send_frame(4'($urandom), MY_ADDR, 2'($urandom), rd, 1'b0);
    end
    idle(2);
    check_eq("b2b_pulses", 64'(n_valid), 64'd256);
    check_eq("b2b_count",  intf.rx_count, 64'(exp_count));

    // Reset in the middle of a frame, then a complete good frame.
    begin
      logic [78:0] fr;
      fr = make_frame(4'd6, MY_ADDR, 2'b11, 64'hAAAA_5555_AAAA_5555, 1'b0);
      for (int j = 0; j <= 40; j++) step(fr[78-j], 1'b0, 1'b1);
    end
    do_reset(1);
    idle(2);
    n_valid = 0;
    send_frame(4'd2, MY_ADDR, 2'b00, 64'h0BAD_CAFE_1234_5678, 1'b0);
    idle(3);
    check_eq("rst_pulses", 64'(n_valid), 64'd1);
    check_eq("rst_count",  intf.rx_count, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rx_node.md
# bus_rx_node

Serial bus receiver node: the far end of the shared single-wire `bus_out` line driven by the 16-node `FPGA` transmitter.
- Samples the line one bit per `clock` and deframes 79-bit packets.
- Filters packets on destination address and checks the 4-bit CRC.
- Presents the accepted 64-bit payload, source address and mode to local logic.
- One instance per node; the testbench instantiates it beside the transmitter to close the loop.

## Interface
Parameters:
- `MY_ADDR`, default 4'd1: this node's 4-bit address.
- `BCAST_MOD`, default 2'b01: mode value that means broadcast (destination address is ignored).

Ports:
- `clock` input 1: single clock; one bus bit per rising edge.
- `reset` input 1: synchronous, active-high.
- `bus_in` input 1: serial line, connected to the transmitter's `bus_out`; idles low.
- `rx_valid` output 1: one-cycle pulse when a frame is accepted.
- `rx_data` output 64: payload of the last accepted frame.
- `rx_src` output 4: sender address of the last accepted frame.
- `rx_mod` output 2: mode field of the last accepted frame.
- `crc_err` output 1: one-cycle pulse when a frame addressed to this node fails CRC.
- `busy` output 1: high while a frame is being shifted in.
- `rx_count` output 8: count of accepted frames; wraps 255→0.

## Operation
- Frame order on the line, each field MSB first:
  - start bit = 1
  - src[3:0]
  - dst[3:0]
  - mod[1:0]
  - data[63:0]
  - crc[3:0]
  - Total 79 bits.
- CRC definition:
  - CRC-4, polynomial x^4+x+1, initial value 0.
  - Covers the 74 bits src..data in line order. The start bit and the crc field are excluded.
  - Computed serially as bits arrive.
- FSM states:
  - IDLE: stays while `bus_in`=0. `bus_in`=1 → SRC.
  - SRC: 4 bits → DST.
  - DST: 4 bits → MOD.
  - MOD: 2 bits → DATA.
  - DATA: 64 bits → CRC.
  - CRC: 4 bits → IDLE.
- A single 7-bit bit counter is reloaded on each field entry.
- Frame evaluation happens on the edge that samples the last crc bit:
  - **Match** = (dst == `MY_ADDR`) or (mod == `BCAST_MOD`).
  - Match and CRC good → `rx_valid` pulses; `rx_data`, `rx_src` and `rx_mod` load; `rx_count` increments.
  - Match and CRC bad → `crc_err` pulses; data outputs keep their previous values; `rx_count` unchanged.
  - No match → silent discard, no pulses.
- Data outputs hold their values until the next accepted frame.
- Mode values other than `BCAST_MOD` are passed through to `rx_mod` uninterpreted.

## Timing
- Reset values:
  - State: IDLE.
  - All outputs 0: `rx_valid`, `crc_err`, `busy`, `rx_data`, `rx_src`, `rx_mod`, `rx_count`.
- Edge numbering: start bit sampled on edge 0; last crc bit sampled on edge 78.
- `busy`:
  - Registered.
  - High from the cycle after edge 0 through the cycle after edge 77.
  - Low once the FSM is back in IDLE.
- `rx_valid` / `crc_err`:
  - Registered; high for exactly the one cycle following edge 78.
  - Never both high together.
- Back-to-back frames: a start bit sampled on edge 79 (zero gap) is accepted. The evaluation pulse and the new frame's first state coexist.
- `reset` mid-frame: the partial frame is abandoned, the FSM returns to IDLE and all outputs clear on that edge. A line still high after reset deasserts is treated as a start bit.
- `rx_count`:
  - Increments on the accept edge.
  - 8'hFF + 1 → 8'h00; no saturation.

## Configuration
- `BUS_RX_CRC_CHECK_EN` defined:
  - CRC is computed and compared as described.
  - `crc_err` is live.
- `BUS_RX_CRC_CHECK_EN` undefined:
  - The crc field is still shifted in (frame length stays 79) but is ignored.
  - Every matching frame is accepted.
  - `crc_err` is tied 0.
  - No CRC logic is synthesized.

## Structure
- Shared package `bus_pkg` holds:
  - Field widths: ADDR_W=4, MOD_W=2, DATA_W=64, CRC_W=4, FRAME_LEN=79.
  - The state enum.
  - CRC polynomial constant 4'b0011.
  - A `crc4_next(crc, bit)` function, also used by the transmitter.
- Sub-module `bus_crc4_ser`: a serial CRC-4 register with clear and enable. It is instantiated only under `BUS_RX_CRC_CHECK_EN`.
- Everything else (FSM, shift register, filter, counter) lives in `bus_rx_node`.

## Test plan
- **Unicast accept.** Stimulus: `MY_ADDR`=1; frame src=0, dst=1, mod=01, data=64'h1, correct CRC. Required: `rx_valid` one cycle after edge 78; `rx_data`=64'h1; `rx_src`=0; `rx_count`=1.
- **Address filter.** Stimulus: dst=2, mod=00, data=64'hDEAD_BEEF. Required: no `rx_valid`, no `crc_err`; outputs unchanged.
- **Broadcast.** Stimulus: dst=7, mod=01, data=64'hFFFF_0000_FFFF_0000. Required: accepted.
- **CRC error.** Stimulus: valid frame to dst=1 with crc bit 0 flipped. Required: `crc_err` pulse; `rx_data` unchanged; `rx_count` unchanged. With the macro undefined: accepted instead.
- **Back-to-back and wrap.** Stimulus: 256 consecutive zero-gap frames to dst=1. Required: 256 `rx_valid` pulses; `rx_count` ends at 0.
- **Reset mid-frame.** Stimulus: `reset` pulsed at bit 40, then a complete good frame. Required: only the second frame is accepted; `rx_count`=1.
